// File: rtl/fir_xifu_offloader.sv
// fir_xifu_offloader
// Core-side issuer for the FIR extension. Takes instructions from decode, offloads
// xfirlw / xfirsw / xfirdotp to the FIR coprocessor over issue/commit/result and writes
// returned results into the core register file. A per-register pending mask blocks
// RAW/WAW hazards while results are outstanding.
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   instr_valid_i/instr_ready_o/instr_i decode-stage instruction handshake
//   rf_raddr_*_o, rf_rdata_*_i          operand reads (combinational)
//   rf_we_o/rf_waddr_o/rf_wdata_o       result write port
//   issue_*                             issue handshake towards the coprocessor
//   commit_*                            one-cycle commit strobe, kill on flush_i
//   result_*                            result handshake from the coprocessor
//   illegal_o                           one-cycle pulse after a rejected instruction
module fir_xifu_offloader #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [31:0]         instr_i,
    output logic [4:0]          rf_raddr_a_o,
    output logic [4:0]          rf_raddr_b_o,
    input  logic [31:0]         rf_rdata_a_i,
    input  logic [31:0]         rf_rdata_b_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic                issue_valid_o,
    input  logic                issue_ready_i,
    output logic [31:0]         issue_instr_o,
    output logic [ID_WIDTH-1:0] issue_id_o,
    output logic [31:0]         issue_rs1_o,
    output logic [31:0]         issue_rs2_o,
    input  logic                issue_accept_i,
    input  logic                issue_writeback_i,
    output logic                commit_valid_o,
    output logic [ID_WIDTH-1:0] commit_id_o,
    output logic                commit_kill_o,
    input  logic                flush_i,
    input  logic                result_valid_i,
    output logic                result_ready_o,
    input  logic [ID_WIDTH-1:0] result_id_i,
    input  logic [4:0]          result_rd_i,
    input  logic [31:0]         result_data_i,
    input  logic                result_we_i,
    output logic                illegal_o
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIssue  = 2'd1;
    localparam logic [1:0] StCommit = 2'd2;

    logic [1:0]          r_state, w_state_d;
    logic                r_active;
    logic [31:0]         r_pending, w_pending_d;
    logic [ID_WIDTH-1:0] r_id, r_commit_id;
    logic [OutW-1:0]     r_outstanding, w_outstanding_d;
    logic                r_illegal;
    logic [31:0]         r_instr, r_rs1, r_rs2;
    logic                r_set_pend, r_set_inc;

    logic                w_legal, w_uses_rs2, w_uses_rd, w_hazard;
    logic [2:0]          w_funct3;
    logic                w_instr_hs, w_issue_hs, w_res_hs, w_kill;
    logic                w_set_pend, w_out_inc;
    logic [OutW:0]       w_out_sum, w_out_sub;

    // Result IDs are not tracked; results are written back regardless of ID.
    logic w_unused_result_id;
    assign w_unused_result_id = ^result_id_i;

    // Decode of the instruction currently offered by decode
    assign w_funct3   = instr_i[14:12];
    assign w_legal    = (instr_i[6:0] == 7'b1011011) &&
                        (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010);
    assign w_uses_rs2 = (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
    assign w_uses_rd  = (w_funct3 == 3'b000) || (w_funct3 == 3'b010);
    assign w_hazard   = r_pending[instr_i[19:15]] ||
                        (w_uses_rs2 && r_pending[instr_i[24:20]]) ||
                        (w_uses_rd && r_pending[instr_i[11:7]]);

    assign rf_raddr_a_o = instr_i[19:15];
    assign rf_raddr_b_o = instr_i[24:20];

    // Illegal instructions are always taken so they can be rejected promptly.
    assign instr_ready_o = r_active && (r_state == StIdle) && instr_valid_i &&
                           (!w_legal || (!w_hazard &&
                                         r_outstanding < OutW'(MAX_OUTSTANDING)));

    assign issue_valid_o  = (r_state == StIssue);
    assign issue_instr_o  = r_instr;
    assign issue_id_o     = r_id;
    assign issue_rs1_o    = r_rs1;
    assign issue_rs2_o    = r_rs2;

    assign commit_valid_o = (r_state == StCommit);
    assign commit_id_o    = r_commit_id;
    assign commit_kill_o  = commit_valid_o && flush_i;

    assign result_ready_o = r_active;
    assign illegal_o      = r_illegal;

    assign w_instr_hs = instr_valid_i && instr_ready_o;
    assign w_issue_hs = issue_valid_o && issue_ready_i;
    assign w_res_hs   = result_valid_i && result_ready_o;
    assign w_kill     = commit_kill_o;

    assign w_out_inc  = w_issue_hs && issue_accept_i && issue_writeback_i;
    assign w_set_pend = w_out_inc && (r_instr[11:7] != 5'd0);

    assign rf_we_o    = w_res_hs && result_we_i && (result_rd_i != 5'd0);
    assign rf_waddr_o = result_rd_i;
    assign rf_wdata_o = result_data_i;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (w_instr_hs && w_legal) w_state_d = StIssue;
            StIssue:  if (w_issue_hs) w_state_d = issue_accept_i ? StCommit : StIdle;
            StCommit: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Set and clear target different registers (WAW stall), so order is immaterial.
    always_comb begin
        w_pending_d = r_pending;
        if (rf_we_o) w_pending_d[result_rd_i] = 1'b0;
        if (w_set_pend) w_pending_d[r_instr[11:7]] = 1'b1;
        if (w_kill && r_set_pend) w_pending_d[r_instr[11:7]] = 1'b0;
        w_pending_d[0] = 1'b0;
    end

    // Decrements saturate at zero so stray results cannot underflow the count.
    always_comb begin
        w_out_sum = (OutW + 1)'(r_outstanding) + (OutW + 1)'(w_out_inc);
        w_out_sub = (OutW + 1)'(w_res_hs) + (OutW + 1)'(w_kill && r_set_inc);
        if (w_out_sum > w_out_sub) begin
            w_outstanding_d = OutW'(w_out_sum - w_out_sub);
        end else begin
            w_outstanding_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= StIdle;
            r_active      <= 1'b0;
            r_pending     <= '0;
            r_id          <= '0;
            r_commit_id   <= '0;
            r_outstanding <= '0;
            r_illegal     <= 1'b0;
            r_instr       <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_set_pend    <= 1'b0;
            r_set_inc     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_active      <= 1'b1;
            r_pending     <= w_pending_d;
            r_outstanding <= w_outstanding_d;
            r_illegal     <= (w_instr_hs && !w_legal) || (w_issue_hs && !issue_accept_i);
            if (w_instr_hs && w_legal) begin
                r_instr <= instr_i;
                r_rs1   <= rf_rdata_a_i;
                r_rs2   <= rf_rdata_b_i;
            end
            if (w_issue_hs) begin
                r_id        <= r_id + ID_WIDTH'(1);
                r_commit_id <= r_id;
                r_set_pend  <= w_set_pend;
                r_set_inc   <= w_out_inc;
            end
        end
    end

endmodule

// File: tb/tb_fir_xifu_offloader.sv
// Directed bench for fir_xifu_offloader: issue path, hazards, illegal rejects,
// kills, outstanding limit, ID wrap and mid-transaction reset.
module tb_fir_xifu_offloader;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i, instr_ready_o;
    logic [31:0] instr_i;
    logic [4:0]  rf_raddr_a_o, rf_raddr_b_o;
    logic [31:0] rf_rdata_a_i, rf_rdata_b_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        issue_valid_o, issue_ready_i;
    logic [31:0] issue_instr_o;
    logic [3:0]  issue_id_o;
    logic [31:0] issue_rs1_o, issue_rs2_o;
    logic        issue_accept_i, issue_writeback_i;
    logic        commit_valid_o;
    logic [3:0]  commit_id_o;
    logic        commit_kill_o, flush_i;
    logic        result_valid_i, result_ready_o;
    logic [3:0]  result_id_i;
    logic [4:0]  result_rd_i;
    logic [31:0] result_data_i;
    logic        result_we_i;
    logic        illegal_o;

    logic [31:0] regs [32];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  exp_id = 4'd0;

    assign rf_rdata_a_i = regs[rf_raddr_a_o];
    assign rf_rdata_b_i = regs[rf_raddr_b_o];

    always #5 clk = ~clk;

    fir_xifu_offloader #(.ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_id_o(issue_id_o),
        .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o),
        .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
        .commit_kill_o(commit_kill_o), .flush_i(flush_i),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
        .result_id_i(result_id_i), .result_rd_i(result_rd_i),
        .result_data_i(result_data_i), .result_we_i(result_we_i),
        .illegal_o(illegal_o)
    );

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, f3, rd, 7'b1011011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and wait (bounded) for the handshake; ends in the cycle after.
    task automatic accept_instr(input logic [31:0] ins, input int max_wait, input string tag,
                                output int n);
        instr_valid_i = 1'b1;
        instr_i = ins;
        n = 0;
        #1;
        while (!instr_ready_o && n < max_wait) begin
            tick();
            #1;
            n++;
        end
        chk({tag, " accepted"}, {31'd0, instr_ready_o}, 32'd1);
        tick();
        instr_valid_i = 1'b0;
        instr_i = '0;
    endtask

    // Entered in the first ISSUE cycle; leaves the DUT back in IDLE.
    task automatic offload(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int dly, input logic acc, input logic wb, input logic fl,
                           input string tag);
        logic [3:0] cid;
        #1;
        chk({tag, " issue_valid"}, {31'd0, issue_valid_o}, 32'd1);
        chk({tag, " issue_id"}, {28'd0, issue_id_o}, {28'd0, exp_id});
        chk({tag, " issue_rs1"}, issue_rs1_o, rs1);
        chk({tag, " issue_rs2"}, issue_rs2_o, rs2);
        for (int i = 0; i < dly; i++) begin
            tick();
            #1;
            chk({tag, " hold valid"}, {31'd0, issue_valid_o}, 32'd1);
            chk({tag, " hold instr"}, issue_instr_o, ins);
            chk({tag, " hold id"}, {28'd0, issue_id_o}, {28'd0, exp_id});
            chk({tag, " hold rs1"}, issue_rs1_o, rs1);
        end
        issue_ready_i = 1'b1;
        issue_accept_i = acc;
        issue_writeback_i = wb;
        tick();
        issue_ready_i = 1'b0;
        issue_accept_i = 1'b0;
        issue_writeback_i = 1'b0;
        cid = exp_id;
        exp_id = exp_id + 4'd1;
        #1;
        chk({tag, " issue_valid drop"}, {31'd0, issue_valid_o}, 32'd0);
        if (acc) begin
            chk({tag, " commit_valid"}, {31'd0, commit_valid_o}, 32'd1);
            chk({tag, " commit_id"}, {28'd0, commit_id_o}, {28'd0, cid});
            flush_i = fl;
            #1;
            chk({tag, " commit_kill"}, {31'd0, commit_kill_o}, {31'd0, fl});
            tick();
            flush_i = 1'b0;
            #1;
            chk({tag, " commit_valid drop"}, {31'd0, commit_valid_o}, 32'd0);
        end else begin
            chk({tag, " reject illegal"}, {31'd0, illegal_o}, 32'd1);
            chk({tag, " reject no commit"}, {31'd0, commit_valid_o}, 32'd0);
            tick();
            #1;
            chk({tag, " illegal drop"}, {31'd0, illegal_o}, 32'd0);
        end
    endtask

    task automatic do_result(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d,
                             input logic we, input logic exp_we, input string tag);
        result_valid_i = 1'b1;
        result_id_i = id;
        result_rd_i = rd;
        result_data_i = d;
        result_we_i = we;
        #1;
        chk({tag, " result_ready"}, {31'd0, result_ready_o}, 32'd1);
        chk({tag, " rf_we"}, {31'd0, rf_we_o}, {31'd0, exp_we});
        if (exp_we) begin
            chk({tag, " rf_waddr"}, {27'd0, rf_waddr_o}, {27'd0, rd});
            chk({tag, " rf_wdata"}, rf_wdata_o, d);
        end
        tick();
        result_valid_i = 1'b0;
        result_we_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] ins;
        logic [31:0] bad [2];

        for (int i = 0; i < 32; i++) regs[i] = i << 4;
        rst_ni = 1'b0;
        instr_valid_i = 1'b0; instr_i = '0;
        issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
        flush_i = 1'b0;
        result_valid_i = 1'b0; result_id_i = '0; result_rd_i = '0;
        result_data_i = '0; result_we_i = 1'b0;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst instr_ready", {31'd0, instr_ready_o}, 32'd0);
        chk("rst issue_valid", {31'd0, issue_valid_o}, 32'd0);
        chk("rst commit_valid", {31'd0, commit_valid_o}, 32'd0);
        chk("rst illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst rf_we", {31'd0, rf_we_o}, 32'd0);
        chk("rst result_ready", {31'd0, result_ready_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        tick();

        // xfirdotp x5 <- x1, x2
        ins = mk(3'b010, 5'd5, 5'd1, 5'd2);
        accept_instr(ins, 4, "dotp", n);
        chk("dotp no stall", n, 0);
        chk("dotp issue_instr", issue_instr_o, ins);
        offload(ins, 32'h10, 32'h20, 0, 1'b1, 1'b1, 1'b0, "dotp");
        do_result(4'd0, 5'd5, 32'h1234, 1'b1, 1'b1, "dotp res");

        // RAW: xfirlw x3 then xfirdotp x6 <- x3, x1
        ins = mk(3'b000, 5'd3, 5'd1, 5'd0);
        accept_instr(ins, 4, "lw x3", n);
        offload(ins, 32'h10, 32'h0, 0, 1'b1, 1'b1, 1'b0, "lw x3");
        ins = mk(3'b010, 5'd6, 5'd3, 5'd1);
        instr_valid_i = 1'b1;
        instr_i = ins;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("raw blocked", {31'd0, instr_ready_o}, 32'd0);
            tick();
        end
        result_valid_i = 1'b1; result_id_i = 4'd1; result_rd_i = 5'd3;
        result_data_i = 32'hbeef; result_we_i = 1'b1;
        #1;
        chk("raw blocked at result", {31'd0, instr_ready_o}, 32'd0);
        chk("raw result rf_we", {31'd0, rf_we_o}, 32'd1);
        tick();
        result_valid_i = 1'b0; result_we_i = 1'b0;
        accept_instr(ins, 0, "raw released", n);
        offload(ins, 32'h30, 32'h10, 0, 1'b1, 1'b1, 1'b0, "dotp x6");
        do_result(4'd2, 5'd6, 32'h55, 1'b1, 1'b1, "x6 res");

        // Wrong opcode and reserved funct3
        bad[0] = {7'd0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011};
        bad[1] = mk(3'b011, 5'd4, 5'd1, 5'd2);
        for (int i = 0; i < 2; i++) begin
            accept_instr(bad[i], 2, "illegal", n);
            #1;
            chk("illegal no issue", {31'd0, issue_valid_o}, 32'd0);
            chk("illegal pulse", {31'd0, illegal_o}, 32'd1);
            tick();
            #1;
            chk("illegal pulse end", {31'd0, illegal_o}, 32'd0);
        end

        // Delayed issue_ready, then coprocessor rejects xfirlw x9
        ins = mk(3'b000, 5'd9, 5'd1, 5'd0);
        accept_instr(ins, 4, "lw x9", n);
        offload(ins, 32'h10, 32'h0, 3, 1'b0, 1'b1, 1'b0, "lw x9 rej");
        ins = mk(3'b010, 5'd10, 5'd9, 5'd2);
        accept_instr(ins, 0, "x9 not pending", n);
        offload(ins, 32'h90, 32'h20, 0, 1'b1, 1'b0, 1'b0, "dotp x10");

        // Kill at commit of xfirlw x7
        ins = mk(3'b000, 5'd7, 5'd1, 5'd0);
        accept_instr(ins, 4, "lw x7", n);
        offload(ins, 32'h10, 32'h0, 0, 1'b1, 1'b1, 1'b1, "lw x7 kill");
        ins = mk(3'b010, 5'd11, 5'd7, 5'd1);
        accept_instr(ins, 0, "x7 not pending", n);
        offload(ins, 32'h70, 32'h10, 0, 1'b1, 1'b0, 1'b0, "dotp x11");

        // Outstanding limit: four xfirlw in flight, fifth stalls
        for (int r = 1; r <= 4; r++) begin
            ins = mk(3'b000, 5'(r), 5'd10, 5'd0);
            accept_instr(ins, 0, "lw burst", n);
            offload(ins, 32'ha0, 32'h0, 0, 1'b1, 1'b1, 1'b0, "lw burst");
        end
        ins = mk(3'b000, 5'd8, 5'd10, 5'd0);
        instr_valid_i = 1'b1;
        instr_i = ins;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("max stall", {31'd0, instr_ready_o}, 32'd0);
            tick();
        end
        result_valid_i = 1'b1; result_id_i = 4'd7; result_rd_i = 5'd1;
        result_data_i = 32'h1; result_we_i = 1'b1;
        #1;
        chk("max stall at result", {31'd0, instr_ready_o}, 32'd0);
        tick();
        result_valid_i = 1'b0; result_we_i = 1'b0;
        accept_instr(ins, 0, "max released", n);
        offload(ins, 32'ha0, 32'h0, 0, 1'b1, 1'b1, 1'b0, "lw x8");
        do_result(4'd8, 5'd2, 32'h2, 1'b1, 1'b1, "drain x2");
        do_result(4'd9, 5'd3, 32'h3, 1'b1, 1'b1, "drain x3");
        do_result(4'd10, 5'd4, 32'h4, 1'b1, 1'b1, "drain x4");
        do_result(4'd11, 5'd8, 32'h8, 1'b1, 1'b1, "drain x8");

        // ID wrap with xfirsw, last one writes back to x0
        ins = mk(3'b001, 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 16 && exp_id != 4'd0; i++) begin
            accept_instr(ins, 0, "sw", n);
            offload(ins, 32'h10, 32'h20, 0, 1'b1, 1'b0, 1'b0, "sw");
        end
        accept_instr(ins, 0, "sw wrap", n);
        #1;
        chk("id wrapped", {28'd0, issue_id_o}, 32'd0);
        offload(ins, 32'h10, 32'h20, 0, 1'b1, 1'b1, 1'b0, "sw wrap");
        do_result(4'd0, 5'd0, 32'hdead, 1'b1, 1'b0, "x0 res");

        // Reset while issuing xfirlw x12
        ins = mk(3'b000, 5'd12, 5'd1, 5'd0);
        accept_instr(ins, 4, "lw x12", n);
        #1;
        chk("pre-reset issue_valid", {31'd0, issue_valid_o}, 32'd1);
        rst_ni = 1'b0;
        tick();
        #1;
        chk("mid-reset issue_valid", {31'd0, issue_valid_o}, 32'd0);
        chk("mid-reset result_ready", {31'd0, result_ready_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        tick();
        exp_id = 4'd0;
        ins = mk(3'b010, 5'd13, 5'd12, 5'd1);
        accept_instr(ins, 0, "post-reset", n);
        offload(ins, 32'hc0, 32'h10, 0, 1'b1, 1'b0, 1'b0, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_xifu_offloader.md
# fir_xifu_offloader

Core-side issuer for the FIR extension: consumes 32-bit instructions from the core's decode stage, offloads the three FIR custom instructions (xfirlw, xfirsw, xfirdotp) to the FIR coprocessor over the issue/commit/result handshake, and writes returned results into the core register file. It sits between core decode and the FIR XIFU and is the initiator end of the interface the coprocessor answers. A per-register scoreboard blocks RAW/WAW hazards while results are outstanding.

## Interface
- ID_WIDTH, 4, width of the issue/result transaction ID
- MAX_OUTSTANDING, 4, max accepted instructions awaiting a result (1..2^ID_WIDTH)

- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- instr_valid_i / instr_ready_o  in/out  1  decode-stage instruction handshake
- instr_i  in  32  instruction word
- rf_raddr_a_o, rf_raddr_b_o  out  5  register-file read addresses (rs1, rs2)
- rf_rdata_a_i, rf_rdata_b_i  in  32  combinational read data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- issue_valid_o / issue_ready_i  out/in  1  issue handshake
- issue_instr_o  out  32  offloaded instruction
- issue_id_o  out  ID_WIDTH  transaction ID
- issue_rs1_o, issue_rs2_o  out  32  operand values
- issue_accept_i  in  1  coprocessor accepts (valid with issue_ready_i)
- issue_writeback_i  in  1  accepted instruction will return a result
- commit_valid_o  out  1  commit strobe
- commit_id_o  out  ID_WIDTH  committed ID
- commit_kill_o  out  1  kill the issued instruction
- flush_i  in  1  core requests kill of the in-flight instruction
- result_valid_i / result_ready_o  in/out  1  result handshake
- result_id_i  in  ID_WIDTH  result ID
- result_rd_i  in  5  destination register
- result_data_i  in  32  result value
- result_we_i  in  1  result carries a register write
- illegal_o  out  1  one-cycle pulse: instruction rejected

## Operation
- Decode: legal iff opcode[6:0]=7'b1011011 and funct3 ∈ {000 xfirlw, 001 xfirsw, 010 xfirdotp}. Sources: rs1 always; rs2 for xfirsw/xfirdotp. Destination rd (instr[11:7]) for xfirlw/xfirdotp only.
- rf_raddr_a_o=instr_i[19:15], rf_raddr_b_o=instr_i[24:20] (combinational from instr_i).
- Hazard: stall if any used source or destination has its pending bit set. x0 is never pending.
- FSM IDLE/ISSUE/COMMIT:
  - IDLE: instr_ready_o=1 iff instr_valid_i and (illegal, or no hazard and outstanding<MAX_OUTSTANDING). On legal handshake: latch instr_i, rf_rdata_a_i, rf_rdata_b_i → ISSUE. On illegal handshake: illegal_o pulse next cycle, stay IDLE.
  - ISSUE: issue_valid_o=1, instruction/ID/operands held stable until issue_ready_i. Handshake with issue_accept_i=1: if issue_writeback_i and rd≠0, set pending[rd] and outstanding+=1 (outstanding incremented even for rd=0 when writeback) → COMMIT. Handshake with issue_accept_i=0: illegal_o pulse next cycle → IDLE. ID counter increments (mod 2^ID_WIDTH) on every issue handshake.
  - COMMIT: commit_valid_o=1 one cycle, commit_id_o=issued ID, commit_kill_o=flush_i sampled this cycle. Killed: revert the pending bit and outstanding increment made at accept. → IDLE.
- Result: result_ready_o=1 whenever out of reset. On handshake: outstanding-=1; if result_we_i and result_rd_i≠0: rf_we_o=1, rf_waddr_o=result_rd_i, rf_wdata_o=result_data_i (same cycle, combinational), clear pending[result_rd_i].
- Simultaneous set (issue accept) and clear (result) in one cycle: both applied; different registers guaranteed by WAW stall. Simultaneous outstanding increment and decrement: net unchanged.
- Result with unknown/killed ID: still written if result_we_i; no error reporting.

## Timing
- Reset: all outputs 0 (instr_ready_o, issue_valid_o, commit_valid_o, illegal_o, rf_we_o, result_ready_o), state IDLE, pending mask 0, ID 0, outstanding 0. Reset mid-transaction abandons it; issue_valid_o low the cycle after rst_ni sampled low.
- Minimum offload: accept at cycle 0, issue_valid_o cycle 1, commit cycle 2 (if issue_ready_i at cycle 1); next instruction accepted cycle 3.
- illegal_o asserted exactly one cycle after the rejecting handshake.
- A dependent instruction is accepted the cycle after its blocking result handshake at earliest.

## Test plan
- xfirdotp x5←x1,x2 (rf x1=0x10, x2=0x20), coprocessor accepts with writeback at first ISSUE cycle → issue_rs1_o=0x10, rs2=0x20, ID=0; commit_valid_o two cycles after instr handshake, kill=0; result 0x1234 rd=5 → rf_we_o, waddr 5, wdata 0x1234.
- xfirlw x3 then xfirdotp reading x3 → second instr_ready_o held 0 until result for x3 returns, then accepted next cycle.
- instr_i with opcode 7'b0110011 → no issue_valid_o, illegal_o one cycle after handshake.
- issue_ready_i delayed 3 cycles → issue fields stable; issue_accept_i=0 → illegal_o pulse, pending mask unchanged.
- flush_i high during COMMIT of xfirlw x7 → commit_kill_o=1, pending[7] cleared, outstanding back to 0.
- MAX_OUTSTANDING=4 independent xfirlw x1..x4 without results → fifth stalls; one result releases it; ID wraps 15→0 after 16 issues.
